// File: rtl/clkdiv_cfg_ctrl.sv
// Round-robin ratio-change sequencer for the clock divider: gate enable, settle, load, re-enable.
// Ack SETTLE_CYC+2 edges after grant (next edge if unchanged); held requests wait. Macro CLKDIV_CTRL_RATIO_CHECK_EN rejects ratios 0/1.
module clkdiv_cfg_ctrl #(
  parameter int RATIO_WD      = 4,
  parameter int N_REQ         = 2,
  parameter int SETTLE_CYC    = 4,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic                      I_ref_clk,
  input  logic                      I_rst_n,
  input  logic                      I_sys_en,
  input  logic [N_REQ-1:0]          I_req,
  input  logic [N_REQ*RATIO_WD-1:0] I_ratio,
  output logic [N_REQ-1:0]          O_ack,
  output logic                      O_err,
  output logic                      O_busy,
  output logic [RATIO_WD-1:0]       O_div_ratio,
  output logic                      O_clk_en
);

  localparam int PTR_WD = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, RESTART, DONE} state_t;

  state_t              state, state_nxt;
  logic [PTR_WD-1:0]   ptr, ptr_nxt, idx, idx_nxt, idx_inc;
  logic [RATIO_WD-1:0] shadow, shadow_nxt, ratio_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [N_REQ-1:0]    ack_nxt;
  logic                busy_nxt, clk_en_nxt;
  logic                grant_vld, grant_bad;
  logic [PTR_WD-1:0]   grant_idx;
  logic [RATIO_WD-1:0] grant_ratio;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (I_req[(int'(ptr) + i) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_WD'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign grant_ratio = I_ratio[grant_idx*RATIO_WD +: RATIO_WD];
  assign idx_inc     = (idx == PTR_WD'(N_REQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld)
                 state_nxt = (grant_bad || grant_ratio == O_div_ratio) ? DONE : DRAIN;
      DRAIN:   if (cnt == 4'd0) state_nxt = LOAD;
      LOAD:    state_nxt = RESTART;
      RESTART: state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt    = ptr;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    ratio_nxt  = O_div_ratio;
    cnt_nxt    = cnt;
    ack_nxt    = '0;
    clk_en_nxt = O_clk_en;
    busy_nxt   = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        clk_en_nxt = I_sys_en;
        if (grant_vld) begin
          idx_nxt    = grant_idx;
          shadow_nxt = grant_ratio;
        end
        if (state_nxt == DRAIN) begin
          clk_en_nxt = 1'b0;
          cnt_nxt    = 4'(SETTLE_CYC - 1);
        end
      end
      DRAIN: begin
        clk_en_nxt = 1'b0;
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
      end
      LOAD: begin
        clk_en_nxt = 1'b0;
        ratio_nxt  = shadow;
      end
      RESTART, DONE: begin
        clk_en_nxt   = I_sys_en;
        ack_nxt[idx] = 1'b1;
        ptr_nxt      = idx_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ptr         <= '0;
      idx         <= '0;
      shadow      <= RATIO_WD'(DEFAULT_RATIO);
      cnt         <= '0;
      O_ack       <= '0;
      O_busy      <= 1'b0;
      O_div_ratio <= RATIO_WD'(DEFAULT_RATIO);
      O_clk_en    <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      idx         <= idx_nxt;
      shadow      <= shadow_nxt;
      cnt         <= cnt_nxt;
      O_ack       <= ack_nxt;
      O_busy      <= busy_nxt;
      O_div_ratio <= ratio_nxt;
      O_clk_en    <= clk_en_nxt;
    end
  end

`ifdef CLKDIV_CTRL_RATIO_CHECK_EN
  logic rej;

  // Ratios 0 and 1 would put the divider into bypass; refuse them.
  assign grant_bad = (grant_ratio <= RATIO_WD'(1));

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rej   <= 1'b0;
      O_err <= 1'b0;
    end else begin
      if (state == IDLE && grant_vld) rej <= grant_bad;
      O_err <= (state == DONE) && rej;
    end
  end
`else
  assign grant_bad = 1'b0;
  assign O_err     = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
module tb_clkdiv_cfg_ctrl;
  localparam int RW = 4;
  localparam int N  = 2;
  localparam int S  = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          sys_en = 1'b0;
  logic [N-1:0]  req    = '0;
  logic [N*RW-1:0] ratio = '0;
  logic [N-1:0]  ack;
  logic          err, busy, clk_en;
  logic [RW-1:0] div_ratio;

  int checks = 0;
  int errors = 0;

  clkdiv_cfg_ctrl #(.RATIO_WD(RW), .N_REQ(N), .SETTLE_CYC(S), .DEFAULT_RATIO(2)) dut (
    .I_ref_clk(clk), .I_rst_n(rst_n), .I_sys_en(sys_en), .I_req(req), .I_ratio(ratio),
    .O_ack(ack), .O_err(err), .O_busy(busy), .O_div_ratio(div_ratio), .O_clk_en(clk_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a grant opens a window whose outputs follow from the grant edge.
  logic [RW-1:0] m_ratio = 4'd2;
  logic          m_en = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic [N-1:0]  m_ack = '0;
  int            m_ptr = 0;
  bit            act_m = 0, chg = 0, g_bad = 0;
  int            phase = 0, g_idx = 0;
  logic [RW-1:0] g_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ratio = 4'd2; m_en = 0; m_busy = 0; m_err = 0; m_ack = '0;
      m_ptr = 0; act_m = 0; phase = 0;
    end else begin
      m_ack = '0;
      m_err = 0;
      if (!act_m) begin
        bit found;
        found = 0;
        m_en = sys_en;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && req[j]) begin
            found = 1;
            g_idx = j;
          end
        end
        if (found) begin
          g_r = ratio[g_idx*RW +: RW];
`ifdef CLKDIV_CTRL_RATIO_CHECK_EN
          g_bad = (g_r < 2);
`else
          g_bad = 0;
`endif
          chg    = !g_bad && (g_r != m_ratio);
          act_m  = 1;
          phase  = 0;
          m_busy = 1;
          if (chg) m_en = 0;
        end
      end else begin
        phase++;
        if (chg && phase <= S + 1) begin
          m_en = 0;
          if (phase == S + 1) m_ratio = g_r;
        end else begin
          m_en         = sys_en;
          m_ack[g_idx] = 1'b1;
          m_err        = g_bad;
          m_busy       = 0;
          m_ptr        = (g_idx + 1) % N;
          act_m        = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_ratio", div_ratio, m_ratio);
    check("cyc_en", clk_en, m_en);
    check("cyc_ack", ack, m_ack);
    check("cyc_err", err, m_err);
    check("cyc_busy", busy, m_busy);
  end

  task automatic do_req(input int i, input logic [RW-1:0] r, output int lat, output int lowc,
                        output logic [RW-1:0] prev_r, output logic [N-1:0] a, output logic e);
    lat = 0; lowc = 0; prev_r = div_ratio; a = '0; e = 0;
    ratio[i*RW +: RW] = r;
    req[i] = 1'b1;
    for (int c = 1; c <= 60 && a == '0; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        a = ack; e = err; lat = c;
      end else begin
        if (!clk_en) lowc++;
        prev_r = div_ratio;
      end
    end
    req[i] = 1'b0;
    if (a == '0) check("ack_timeout", 0, 1);
  endtask

  initial begin
    int lat, lowc;
    logic [RW-1:0] pr;
    logic [N-1:0] a;
    logic e;
    logic [N-1:0] order [2];
    logic [RW-1:0] rat_at [2];
    int n;

    sys_en = 1;
    repeat (2) @(negedge clk);
    check("rst_ratio", div_ratio, 2);
    check("rst_en", clk_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    rst_n = 1;
    @(negedge clk);
    check("en_after_rst", clk_en, 1);

    do_req(0, 4'd6, lat, lowc, pr, a, e);
    check("chg_ack", a, 2'b01);
    check("chg_latency", lat, 7);
    check("chg_en_low", lowc, 6);
    check("chg_ratio_before_rise", pr, 6);
    check("chg_en_at_ack", clk_en, 1);
    check("chg_err", e, 0);

    @(negedge clk);
    do_req(0, 4'd6, lat, lowc, pr, a, e);
    check("same_ack", a, 2'b01);
    check("same_latency", lat, 2);
    check("same_en_low", lowc, 0);

    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    ratio = {4'd8, 4'd4};
    req   = 2'b11;
    n = 0;
    for (int c = 0; c < 100 && n < 2; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        order[n] = ack; rat_at[n] = div_ratio; n++;
        req = req & ~ack;
      end
    end
    req = '0;
    check("rr_count", n, 2);
    check("rr_first", order[0], 2'b01);
    check("rr_first_ratio", rat_at[0], 4);
    check("rr_second", order[1], 2'b10);
    check("rr_second_ratio", rat_at[1], 8);

    @(negedge clk);
    ratio = {4'd8, 4'd4};
    req   = 2'b11;
    n = 0;
    for (int c = 0; c < 100 && n < 2; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        order[n] = ack; n++;
        req = req & ~ack;
      end
    end
    req = '0;
    check("rr_ptr_wrap", order[0], 2'b01);

    @(negedge clk);
    ratio[3:0] = 4'd3;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    req[0] = 1'b0;
    #1;
    check("abort_ratio", div_ratio, 2);
    check("abort_en", clk_en, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    @(negedge clk);
    check("abort_no_ack", ack, 0);
    #2 rst_n = 1;
    @(negedge clk);
    do_req(0, 4'd3, lat, lowc, pr, a, e);
    check("reissue_ack", a, 2'b01);
    check("reissue_ratio", div_ratio, 3);

    @(negedge clk);
    do_req(1, 4'd1, lat, lowc, pr, a, e);
    check("r1_ack", a, 2'b10);
`ifdef CLKDIV_CTRL_RATIO_CHECK_EN
    check("r1_err", e, 1);
    check("r1_latency", lat, 2);
    check("r1_ratio_kept", div_ratio, 3);
    check("r1_en_low", lowc, 0);
`else
    check("r1_err", e, 0);
    check("r1_latency", lat, 7);
    check("r1_ratio_loaded", div_ratio, 1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clkdiv_cfg_ctrl.md
Name: clkdiv_cfg_ctrl

Overview:
- Configuration sequencer and arbiter for the parameterized clock divider. Several requesters may ask for a new division ratio; this block grants them round-robin.
- Ratio changes are made safe by sequencing: gate the divider enable, wait a settle window, load the new ratio, then re-enable.
- Sits beside the divider in the ref-clock domain and drives its ratio and enable inputs.

Parameters:
- RATIO_WD, 4, width of a division ratio; matches divider ratio width.
- N_REQ, 2, number of requesters (2..8).
- SETTLE_CYC, 4, ref-clock cycles the enable stays low before a new ratio is loaded (1..15).
- DEFAULT_RATIO, 2, ratio driven out of reset.

Ports:
- I_ref_clk  in  1  reference clock; all logic on its rising edge.
- I_rst_n  in  1  asynchronous active-low reset.
- I_sys_en  in  1  global divider enable request.
- I_req  in  N_REQ  per-requester ratio-change request, level.
- I_ratio  in  N_REQ*RATIO_WD  requested ratios; requester i uses slice [i*RATIO_WD +: RATIO_WD].
- O_ack  out  N_REQ  one-cycle completion pulse, one-hot.
- O_err  out  1  one-cycle reject pulse, coincident with O_ack.
- O_busy  out  1  high whenever the FSM is not in IDLE.
- O_div_ratio  out  RATIO_WD  ratio to the divider.
- O_clk_en  out  1  enable to the divider.

Behaviour:
- Clock and reset: one clock, I_ref_clk. Reset is asynchronous, active-low (I_rst_n).
- Reset values:
  - O_div_ratio = DEFAULT_RATIO.
  - O_clk_en = 0; O_ack = 0; O_err = 0; O_busy = 0.
  - Round-robin pointer = 0; FSM = IDLE.
- All outputs are registered.
- Handshake:
  - Requester i raises I_req[i] and holds its I_ratio slice stable until O_ack[i].
  - A request dropped before it is granted is ignored.
  - The ratio is captured into a shadow register at grant. Dropping I_req after grant does not abort the sequence.
  - A requester must deassert I_req[i] in the cycle after O_ack[i], otherwise it is re-arbitrated as a new request.
- Arbitration (IDLE only): grant the first asserted I_req at or after the pointer, wrapping. After its O_ack, pointer = granted index + 1 mod N_REQ.
- FSM states: IDLE, DRAIN, LOAD, RESTART, DONE.
- IDLE:
  - O_clk_en <= I_sys_en every cycle.
  - On a grant, capture the index and ratio; O_busy <= 1.
  - If the captured ratio equals O_div_ratio, go to DONE; no enable glitch.
  - Otherwise O_clk_en <= 0, load the settle counter, go to DRAIN.
- DRAIN: O_clk_en held 0; count SETTLE_CYC cycles, then go to LOAD.
- LOAD: O_div_ratio <= shadow ratio; go to RESTART.
- RESTART: O_clk_en <= I_sys_en; O_ack[idx] pulses; go to IDLE with O_busy <= 0.
- DONE: O_ack[idx] pulses; go to IDLE.
- Latency, measured from the IDLE edge that grants:
  - Change: ack after SETTLE_CYC+2 further edges; O_clk_en low for exactly SETTLE_CYC+2 cycles when I_sys_en = 1.
  - Same ratio: ack on the next edge.
- I_sys_en = 0 at any time: O_clk_en stays 0 and ratio updates still complete. I_sys_en is ignored during DRAIN and LOAD.
- Simultaneous requests: one grant per sequence. The others wait, held, and are served in round-robin order.
- Reset mid-sequence: immediate return to reset values; no O_ack is issued for the aborted request.
- The settle counter is wide enough to hold 15; no wrap.

Optional Feature:
- Macro: CLKDIV_CTRL_RATIO_CHECK_EN.
- Defined:
  - A granted ratio of 0 or 1 (divider bypass) is rejected.
  - IDLE goes to DONE with O_ack[idx] and O_err pulsing together.
  - O_div_ratio and O_clk_en are unchanged.
- Undefined: O_err is tied to 0, and ratios 0 and 1 are loaded through the normal DRAIN/LOAD path.

Test Plan:
- Reset, then I_sys_en = 1: O_div_ratio = 2, O_clk_en = 0 during reset, O_clk_en = 1 one edge after release; O_busy = 0.
- Req0 ratio 6, SETTLE_CYC = 4, I_sys_en = 1: O_clk_en low exactly 6 cycles; O_div_ratio = 6 one cycle before O_clk_en rises; O_ack = 2'b01 coincident with the rise.
- Req0 ratio equal to current (2): O_ack[0] one edge after the grant; O_clk_en never drops.
- I_req = 2'b11 with ratios 4 and 8, pointer 0: req0 served first (ratio 4); req1 then served (ratio 8); pointer ends at 0.
- Reset asserted during DRAIN: outputs return to reset values at once; no O_ack; a re-issued request completes normally.
- With CLKDIV_CTRL_RATIO_CHECK_EN, req1 ratio 1: O_ack = 2'b10 and O_err = 1 one edge after the grant; ratio and enable unchanged. Without the macro, ratio 1 is loaded and O_err stays 0.
